// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, RV32I width codes and store/alignment helpers for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    return store ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
                 : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction
  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] a);
    return f3[1:0] == 2'b01 ? !a[0] : f3[1:0] == 2'b10 ? a == 2'b00 : 1'b1;
  endfunction
  function automatic logic [3:0] st_mask(input logic [2:0] f3, input logic [1:0] a);
    return f3[1:0] == 2'b00 ? 4'b0001 << a : f3[1:0] == 2'b01 ? 4'b0011 << a : 4'b1111;
  endfunction
  function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [31:0] d);
    return f3[1:0] == 2'b00 ? {4{d[7:0]}} : f3[1:0] == 2'b01 ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half lane of a load word and sign- or zero-extends it
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  logic [31:0] sh;
  logic [7:0]  b;
  logic [15:0] h;
  assign sh = rdata >> {off, 3'b000};
  assign b  = sh[7:0];
  assign h  = sh[15:0];
  assign result = funct3 == F3_B  ? {{24{b[7]}}, b}  :
                  funct3 == F3_BU ? {24'b0, b}       :
                  funct3 == F3_H  ? {{16{h[15]}}, h} :
                  funct3 == F3_HU ? {16'b0, h}       : rdata;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory access FSM with store lane masking, load alignment and bus timeout
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        rg_wr,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic        illegal,
  output logic        bus_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [31:0] a_q, d_q, ld_q, ld_val;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        st_q, req, legal, aligned, start, in_idle, in_acc, in_wb, tmo;
  assign in_idle = state == IDLE;
  assign in_acc  = state == ACCESS;
  assign in_wb   = state == WB;
  assign req     = in_idle & valid_i & (is_load | is_store);
  assign legal   = f3_legal(is_store, funct3);
  assign aligned = f3_aligned(funct3, addr[1:0]);
  assign start   = req & legal & aligned;
  assign tmo     = in_acc & !mem_ack & (cnt == TMAX);
  assign illegal    = req & !legal;
  assign misaligned = req & legal & !aligned;
  assign bus_err    = tmo;
  assign stall      = start | (in_acc & !(mem_ack & st_q) & !tmo);
  assign mem_req    = in_acc;
  assign mem_we     = in_acc & st_q;
  assign mem_addr   = in_acc ? {a_q[31:2], 2'b00} : '0;
  assign mem_wmask  = mem_we ? st_mask(f3_q, a_q[1:0]) : '0;
  assign mem_wdata  = mem_we ? st_data(f3_q, d_q) : '0;
  assign rg_wr      = in_wb & (rd_q != 5'd0);
  assign waddr      = in_wb ? rd_q : '0;
  assign wdata      = in_wb ? ld_q : '0;
  load_align u_align (
    .rdata (mem_rdata),
    .off   (a_q[1:0]),
    .funct3(f3_q),
    .result(ld_val)
  );
  // state register, request latch, wait counter and load capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      d_q   <= '0;
      ld_q  <= '0;
      f3_q  <= '0;
      rd_q  <= '0;
      st_q  <= 1'b0;
    end else begin
      state <= nxt;
      if (start) begin
        a_q  <= addr;
        d_q  <= store_data;
        f3_q <= funct3;
        rd_q <= rd;
        st_q <= is_store;
        cnt  <= '0;
      end else if (in_acc && !mem_ack) begin
        cnt <= cnt + 1'b1;
      end
      if (in_acc && mem_ack && !st_q) ld_q <= ld_val;
    end
  end
  // next state: stores finish on ack, loads detour through WB, timeouts abandon the access
  always_comb begin
    nxt = state;
    nxt = in_idle ? (start ? ACCESS : IDLE) :
          in_acc  ? (mem_ack ? (st_q ? IDLE : WB) : (tmo ? IDLE : ACCESS)) : IDLE;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench for the load/store unit
module tb_load_store_unit;
  localparam int TO = 4;
  logic        clk = 0, rst = 1, valid_i = 0, is_load = 0, is_store = 0, mem_ack = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] addr = 0, store_data = 0, mem_rdata = 0;
  logic [4:0]  rd = 0;
  logic        mem_req, mem_we, stall, rg_wr, misaligned, illegal, bus_err;
  logic [31:0] mem_addr, mem_wdata, wdata;
  logic [3:0]  mem_wmask;
  logic [4:0]  waddr;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .rg_wr(rg_wr), .waddr(waddr), .wdata(wdata), .misaligned(misaligned),
    .illegal(illegal), .bus_err(bus_err)
  );

  typedef enum int {K_MIS, K_ILL, K_ACK, K_WB, K_BERR} kind_e;
  typedef struct {
    kind_e       k;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        we;
  } evt_t;

  evt_t  q[$];
  evt_t  mon_e;
  kind_e mon_k;
  int    n_chk = 0, n_fail = 0;
  logic  mon_on = 0, exp_stall = 0, exp_req = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_legal(bit s, int f3);
    return s ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
  endfunction

  function automatic int unsigned m_size(int f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic logic [31:0] m_load(int f3, logic [31:0] a, logic [31:0] r);
    int unsigned off  = a % 4;
    int unsigned lane = r >> (8 * off);
    int unsigned b    = lane % 256;
    int unsigned h    = lane % 65536;
    case (f3)
      0:       return b >= 128 ? b - 256 : b;
      1:       return h >= 32768 ? h - 65536 : h;
      4:       return b;
      5:       return h;
      default: return r;
    endcase
  endfunction

  function automatic logic [3:0] m_mask(int f3, logic [31:0] a);
    int unsigned off = a % 4;
    return f3 == 0 ? 4'(1 << off) : f3 == 1 ? 4'(3 << off) : 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(int f3, logic [31:0] d);
    return f3 == 0 ? (d % 256) * 32'h0101_0101 : f3 == 1 ? (d % 65536) * 32'h0001_0001 : d;
  endfunction

  // monitor: per-cycle stall/request checks plus scoreboard pops on every DUT event
  always @(negedge clk) begin
    if (mon_on) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      if (misaligned | illegal | bus_err | rg_wr | (mem_req & mem_ack)) begin
        mon_k = misaligned ? K_MIS : illegal ? K_ILL : bus_err ? K_BERR : rg_wr ? K_WB : K_ACK;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: got kind %0d expected none at %0t", mon_k, $time);
        end else begin
          mon_e = q.pop_front();
          chk("event_kind", 32'(mon_k), 32'(mon_e.k));
          if (mon_e.k == K_ACK && mon_k == K_ACK) begin
            chk("mem_addr", mem_addr, mon_e.a);
            chk("mem_we", 32'(mem_we), 32'(mon_e.we));
            if (mon_e.we) begin
              chk("mem_wdata", mem_wdata, mon_e.d);
              chk("mem_wmask", 32'(mem_wmask), 32'(mon_e.m));
            end
          end
          if (mon_e.k == K_WB && mon_k == K_WB) begin
            chk("waddr", 32'(waddr), mon_e.a);
            chk("wdata", wdata, mon_e.d);
          end
        end
      end
    end
  end

  task automatic garbage();
    valid_i    = 1'($urandom % 2);
    is_load    = 1'($urandom % 2);
    is_store   = 1'($urandom % 2);
    funct3     = 3'($urandom);
    addr       = $urandom;
    store_data = $urandom;
    rd         = 5'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_i   = 0;
      mem_ack   = 1'($urandom % 2);
      mem_rdata = $urandom;
      exp_stall = 0;
      exp_req   = 0;
    end
  endtask

  task automatic txn(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input logic [4:0] r, input int dly,
                     input logic [31:0] rdat);
    evt_t e;
    bit   acked;
    int   n;
    @(posedge clk); #1;
    valid_i = 1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd; rd = r;
    mem_ack = 1'($urandom % 2);
    mem_rdata = $urandom;
    exp_req = 0;
    exp_stall = 0;
    if (!(ld || st)) return;
    if (!m_legal(st, int'(f3))) begin
      e.k = K_ILL;
      q.push_back(e);
      return;
    end
    if (a % m_size(int'(f3)) != 0) begin
      e.k = K_MIS;
      q.push_back(e);
      return;
    end
    exp_stall = 1;
    acked = dly < TO;
    n = acked ? dly + 1 : TO;
    if (acked) begin
      e.k = K_ACK; e.a = a - (a % 4); e.we = st; e.m = m_mask(int'(f3), a); e.d = m_wdata(int'(f3), sd);
      q.push_back(e);
      if (!st && r != 0) begin
        e.k = K_WB; e.a = 32'(r); e.d = m_load(int'(f3), a, rdat);
        q.push_back(e);
      end
    end else begin
      e.k = K_BERR;
      q.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      garbage();
      mem_ack   = (k == dly);
      mem_rdata = (k == dly) ? rdat : $urandom;
      exp_req   = 1;
      exp_stall = (k == dly) ? !st : (k == TO - 1) ? 1'b0 : 1'b1;
    end
    if (acked && !st) begin
      @(posedge clk); #1;
      garbage();
      mem_ack   = 1'($urandom % 2);
      exp_req   = 0;
      exp_stall = 0;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wmask"}, 32'(mem_wmask), 0);
    chk({tag, "_stall"}, 32'(stall), 0);
    chk({tag, "_rg_wr"}, 32'(rg_wr), 0);
    chk({tag, "_waddr"}, 32'(waddr), 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_errors"}, 32'({misaligned, illegal, bus_err}), 0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [2:0]  rf;
    int          sel;
    bit          rl, rs;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1;
    rst = 0;
    mon_on = 1;
    txn(1, 0, 3'b010, 32'h0000_0100, 32'h0, 5'd5, 2, 32'h1234_5678);
    txn(1, 0, 3'b000, 32'h0000_0203, 32'h0, 5'd3, 0, 32'h80FF_FF12);
    txn(1, 0, 3'b100, 32'h0000_0203, 32'h0, 5'd4, 1, 32'h80FF_FF12);
    txn(0, 1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 5'd9, 1, 32'h0);
    txn(1, 0, 3'b010, 32'h0000_0101, 32'h0, 5'd6, 0, 32'h0);
    txn(1, 0, 3'b011, 32'h0000_0100, 32'h0, 5'd6, 0, 32'h0);
    txn(0, 1, 3'b100, 32'h0000_0100, 32'h0, 5'd6, 0, 32'h0);
    txn(1, 0, 3'b010, 32'h0000_0200, 32'h0, 5'd8, 9, 32'hDEAD_BEEF);
    txn(0, 1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 5'd1, 3, 32'h0);
    txn(1, 0, 3'b001, 32'h0000_0402, 32'h0, 5'd10, 0, 32'h8001_7FFF);
    txn(1, 0, 3'b101, 32'h0000_0402, 32'h0, 5'd11, 0, 32'h8001_7FFF);
    txn(1, 0, 3'b010, 32'h0000_0500, 32'h0, 5'd0, 1, 32'h5555_AAAA);
    txn(1, 1, 3'b000, 32'h0000_0601, 32'h0000_0077, 5'd2, 0, 32'h0);
    txn(0, 0, 3'b010, 32'h0000_0700, 32'h0, 5'd2, 0, 32'h0);
    idle(2);
    for (int i = 0; i < 300; i++) begin
      sel = $urandom % 10;
      rl = sel < 4 || sel == 8;
      rs = (sel >= 4 && sel < 9);
      rf = ($urandom % 4 == 0) ? 3'($urandom) : 3'(($urandom % 2) ? $urandom % 3 : 4 + $urandom % 2);
      ra = $urandom;
      if ($urandom % 3 != 0) ra = ra - (ra % 4);
      txn(rl, rs, rf, ra, $urandom, 5'($urandom), $urandom % 6, $urandom);
      if ($urandom % 4 == 0) idle(1);
    end
    @(posedge clk); #1;
    valid_i = 1; is_load = 1; is_store = 0; funct3 = 3'b010; addr = 32'h40; rd = 5'd7; mem_ack = 0;
    exp_stall = 1; exp_req = 0;
    q.push_back('{k: K_ACK, a: 32'h40, d: 32'h0, m: 4'h0, we: 1'b0});
    @(posedge clk); #1;
    garbage();
    valid_i = 0; mem_ack = 1; mem_rdata = 32'h1357_9BDF; rst = 1;
    exp_req = 1; exp_stall = 1;
    @(posedge clk); #1;
    rst = 0; valid_i = 0; mem_ack = 0;
    exp_stall = 0; exp_req = 0;
    @(negedge clk);
    chk_quiet("rst_mid_ack");
    idle(4);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, giving the maximum ACCESS cycles without mem_ack before a bus error.
REQ-002 SHALL have one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 valid_i  in  1  a memory instruction is presented this cycle.
REQ-006 is_load / is_store  in  1 each  operation type; both high is treated as store.
REQ-007 funct3  in  3  RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 addr  in  32  effective byte address.
REQ-009 store_data  in  32  register-file rdata2 value.
REQ-010 rd  in  5  load destination register.
REQ-011 mem_req, mem_we  out  1 each  data-memory request and write enable.
REQ-012 mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-013 mem_wdata  out  32  lane-replicated store data; mem_wmask  out  4  byte enables.
REQ-014 mem_ack  in  1  single-cycle completion; mem_rdata  in  32  load word, valid with mem_ack.
REQ-015 stall  out  1  holds upstream pipeline stages.
REQ-016 rg_wr, waddr[5], wdata[32]  out  register-file write port.
REQ-017 misaligned, illegal, bus_err  out  1 each  single-cycle error pulses.

Function
REQ-018 SHALL implement the FSM states IDLE, ACCESS and WB.
REQ-019 start = IDLE & valid_i & (is_load|is_store) & aligned & legal funct3.
- On start, SHALL latch addr, funct3, store_data, rd and op, then move to ACCESS.
REQ-020 Aligned means: H/HU requires addr[0]=0; W requires addr[1:0]=0; B/BU are always aligned.
REQ-021 A misaligned request in IDLE SHALL assert misaligned combinationally that cycle.
- No memory access, state stays IDLE, stall=0.
REQ-022 Load funct3 011/110/111 or store funct3 other than 000/001/010 SHALL assert illegal under the same rules as misaligned.
REQ-023 In ACCESS, mem_req=1 and mem_we=store; mem_addr, mem_wdata and mem_wmask SHALL come only from latched values.
REQ-024 Store mask SHALL be SB 4'b0001<<a[1:0], SH 4'b0011<<a[1:0], SW 4'b1111.
- Data SHALL be replicated: byte x4, half x2.
REQ-025 On ACCESS & mem_ack, a store SHALL go to IDLE and a load SHALL capture the extracted and extended data, then go to WB.
REQ-026 Load extraction SHALL select the lane by a[1:0].
- B/H sign-extend; BU/HU zero-extend; W passes mem_rdata unchanged.
REQ-027 In WB, rg_wr=(rd!=0), waddr=rd and wdata=the captured value for exactly one cycle, then the FSM goes to IDLE.
REQ-028 stall SHALL be start | (ACCESS & !(mem_ack & store) & !timeout).
- stall is 0 in WB and in the completing cycle, so upstream advances on that edge.
- Load latency from start: at least 3 cycles; 1 + ack wait + WB.
REQ-029 A wait counter SHALL clear on start and increment each ACCESS cycle without mem_ack.
- When it reaches TIMEOUT-1 without ack: bus_err=1 and stall=0 that cycle, next state IDLE, no rg_wr.
REQ-030 valid_i while state is ACCESS or WB SHALL be ignored; the request is not latched.
REQ-031 A mem_ack arriving in IDLE or WB SHALL be ignored.
REQ-032 rg_wr, mem_req and all error pulses SHALL be 0 outside the cases above.

Reset
REQ-033 rst SHALL force, on the next edge:
- state IDLE and counter 0;
- mem_req, mem_we, rg_wr, stall, misaligned, illegal and bus_err all 0;
- mem_wmask 0, and mem_addr, mem_wdata, waddr, wdata 0.
REQ-034 rst SHALL override any state, including mid-ACCESS and WB.
- A pending load SHALL never produce rg_wr after reset.

Structure
REQ-035 SHALL use package lsu_pkg holding the state enum and the funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
REQ-036 SHALL instantiate one combinational sub-module, load_align, performing lane select and extension.

Verification
REQ-037 LW at addr 0x100 with ack 2 cycles after the request SHALL produce:
- mem_addr=0x100, mem_req held for 3 cycles;
- rg_wr=1 one cycle, waddr=rd, wdata=mem_rdata;
- stall=0 in WB.
REQ-038 LB at addr 0x203 with mem_rdata=0x80FF_FF12 SHALL give wdata=0xFFFF_FF80; LBU at the same address SHALL give 0x0000_0080.
REQ-039 SH at addr 0x102 with store_data=0x0000_ABCD SHALL give mem_wmask=4'b1100, mem_wdata=0xABCD_ABCD, mem_we=1 and no rg_wr.
REQ-040 LW at addr 0x101 SHALL give misaligned=1 for one cycle, mem_req never asserted and stall=0.
- Funct3 011 load SHALL give illegal=1 under the same conditions.
REQ-041 With TIMEOUT=4 and no ack, SHALL give bus_err=1 in the 4th ACCESS cycle, then IDLE with no rg_wr.
REQ-042 rst asserted in the cycle mem_ack arrives for a load SHALL result in no rg_wr, IDLE next cycle and all outputs 0.
